// File: rtl/d_reg_pkg.sv
// d_reg_pkg: shared mode encoding and lane slicing helper for the register bank
package d_reg_pkg;
    typedef enum logic {
        MODE_DIRECT   = 1'b0,
        MODE_BUFFERED = 1'b1
    } mode_e;
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction
endpackage

// File: rtl/d_reg_bank_dbuf_if.sv
// d_reg_bank_dbuf_if: lane data/control bundle between producer and register bank
interface d_reg_bank_dbuf_if #(
    parameter int WIDTH = 8,
    parameter int CH    = 4
);
    logic [CH*WIDTH-1:0] D;
    logic [CH-1:0]       EN;
    logic                CLR;
    logic                MODE;
    logic                COMMIT;
    logic [CH*WIDTH-1:0] Q;
    logic [CH-1:0]       PEND;
    logic                UPD;
    modport master (output D, EN, CLR, MODE, COMMIT, input Q, PEND, UPD);
    modport slave  (input D, EN, CLR, MODE, COMMIT, output Q, PEND, UPD);
endinterface

// File: rtl/d_reg_lane.sv
// d_reg_lane: one storage lane with shadow register, output register and pending flag
module d_reg_lane import d_reg_pkg::*; #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             clr,
    input  logic             mode,
    input  logic             commit,
    output logic [WIDTH-1:0] q,
    output logic             pend
);
    logic [WIDTH-1:0] sh, q_nx, sh_nx;
    logic             pend_nx, buf_m;
    // outside buffered-pending state the shadow tracks the value Q takes, so a later commit is a no-op
    always_comb begin
        buf_m   = mode == MODE_BUFFERED;
        q_nx    = clr ? RST_VAL : !buf_m ? (en ? d : q) : commit ? (en ? d : sh) : q;
        sh_nx   = clr ? RST_VAL : (!buf_m || commit) ? q_nx : en ? d : sh;
        pend_nx = !clr && buf_m && !commit && (en || pend);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= RST_VAL;
            sh   <= RST_VAL;
            pend <= 1'b0;
        end else begin
            q    <= q_nx;
            sh   <= sh_nx;
            pend <= pend_nx;
        end
    end
endmodule

// File: rtl/d_reg_bank_dbuf.sv
// d_reg_bank_dbuf: CH-lane register bank with direct or shadow-buffered atomic commit
module d_reg_bank_dbuf import d_reg_pkg::*; #(
    parameter int               WIDTH   = 8,
    parameter int               CH      = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input logic                    clk,
    input logic                    rst,
    d_reg_bank_dbuf_if.slave       bus
);
    logic [CH*WIDTH-1:0] q;
    logic [CH-1:0]       pend;
    logic                upd;
    for (genvar i = 0; i < CH; i++) begin : g_lane
        localparam int LO = lane_lo(i, WIDTH);
        d_reg_lane #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .d      (bus.D[LO +: WIDTH]),
            .en     (bus.EN[i]),
            .clr    (bus.CLR),
            .mode   (bus.MODE),
            .commit (bus.COMMIT),
            .q      (q[LO +: WIDTH]),
            .pend   (pend[i])
        );
    end
    // a buffered commit pulses UPD even when CLR wins the data path
    always_ff @(posedge clk or posedge rst) begin
        if (rst) upd <= 1'b0;
        else     upd <= bus.MODE == MODE_BUFFERED && bus.COMMIT;
    end
    assign bus.Q    = q;
    assign bus.PEND = pend;
    assign bus.UPD  = upd;
endmodule

// File: tb/tb_d_reg_bank_dbuf.sv
// tb_d_reg_bank_dbuf: directed vector table plus hand sequences for reset and buffering corners
module tb_d_reg_bank_dbuf;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int compared = 0;
    int mismatched = 0;
    always #5 clk = ~clk;
    d_reg_bank_dbuf_if #(.WIDTH(8), .CH(4)) bus ();
    d_reg_bank_dbuf #(.WIDTH(8), .CH(4), .RST_VAL(8'hA5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    typedef struct {
        logic        mode;
        logic        commit;
        logic        clr;
        logic [3:0]  en;
        logic [31:0] d;
        logic [31:0] q;
        logic [3:0]  pend;
        logic        upd;
    } vec_t;
    vec_t tv[19];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic drive(input logic mode, commit, clr, input logic [3:0] en, input logic [31:0] d);
        bus.MODE = mode;
        bus.COMMIT = commit;
        bus.CLR = clr;
        bus.EN = en;
        bus.D = d;
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    initial begin
        //           mode commit clr  en       d              q              pend     upd
        tv[0]  = '{1'b0, 1'b0, 1'b0, 4'b0101, 32'hDEADBEEF, 32'hA5ADA5EF, 4'b0000, 1'b0};
        tv[1]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 32'hFFFFFFFF, 32'hA5ADA5EF, 4'b0000, 1'b0};
        tv[2]  = '{1'b1, 1'b0, 1'b0, 4'b0001, 32'h00000001, 32'hA5ADA5EF, 4'b0001, 1'b0};
        tv[3]  = '{1'b1, 1'b0, 1'b0, 4'b1000, 32'h04000000, 32'hA5ADA5EF, 4'b1001, 1'b0};
        tv[4]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 32'h00000000, 32'hA5ADA5EF, 4'b1001, 1'b0};
        tv[5]  = '{1'b1, 1'b1, 1'b0, 4'b0000, 32'h00000000, 32'h04ADA501, 4'b0000, 1'b1};
        tv[6]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 32'h00000000, 32'h04ADA501, 4'b0000, 1'b0};
        tv[7]  = '{1'b1, 1'b0, 1'b0, 4'b0100, 32'h00330000, 32'h04ADA501, 4'b0100, 1'b0};
        tv[8]  = '{1'b1, 1'b1, 1'b0, 4'b0100, 32'h00770000, 32'h0477A501, 4'b0000, 1'b1};
        tv[9]  = '{1'b1, 1'b1, 1'b0, 4'b0000, 32'h00000000, 32'h0477A501, 4'b0000, 1'b1};
        tv[10] = '{1'b1, 1'b1, 1'b1, 4'b1111, 32'h12345678, 32'hA5A5A5A5, 4'b0000, 1'b1};
        tv[11] = '{1'b1, 1'b0, 1'b0, 4'b0000, 32'h00000000, 32'hA5A5A5A5, 4'b0000, 1'b0};
        tv[12] = '{1'b1, 1'b1, 1'b0, 4'b0000, 32'h00000000, 32'hA5A5A5A5, 4'b0000, 1'b1};
        tv[13] = '{1'b0, 1'b0, 1'b0, 4'b1111, 32'h10203040, 32'h10203040, 4'b0000, 1'b0};
        tv[14] = '{1'b1, 1'b0, 1'b0, 4'b0010, 32'h00009900, 32'h10203040, 4'b0010, 1'b0};
        tv[15] = '{1'b0, 1'b0, 1'b0, 4'b0000, 32'h00000000, 32'h10203040, 4'b0000, 1'b0};
        tv[16] = '{1'b1, 1'b1, 1'b0, 4'b0000, 32'h00000000, 32'h10203040, 4'b0000, 1'b1};
        tv[17] = '{1'b0, 1'b1, 1'b1, 4'b1111, 32'h55555555, 32'hA5A5A5A5, 4'b0000, 1'b0};
        tv[18] = '{1'b0, 1'b1, 1'b0, 4'b0001, 32'h000000CC, 32'hA5A5A5CC, 4'b0000, 1'b0};
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0);
        step();
        step();
        rst = 1'b0;
        chk("reset_q", bus.Q, 32'hA5A5A5A5);
        chk("reset_pend", {28'h0, bus.PEND}, 32'h0);
        chk("reset_upd", {31'h0, bus.UPD}, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 4'b1111, 32'h11223344);
        step();
        chk("load_q", bus.Q, 32'h11223344);
        drive(1'b1, 1'b0, 1'b0, 4'b0100, 32'h00BB0000);
        step();
        chk("pre_rst_q", bus.Q, 32'h11223344);
        chk("pre_rst_pend", {28'h0, bus.PEND}, 32'h4);
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_q", bus.Q, 32'hA5A5A5A5);
        chk("async_rst_pend", {28'h0, bus.PEND}, 32'h0);
        chk("async_rst_upd", {31'h0, bus.UPD}, 32'h0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 19; i++) begin
            drive(tv[i].mode, tv[i].commit, tv[i].clr, tv[i].en, tv[i].d);
            step();
            chk($sformatf("v%0d_q", i), bus.Q, tv[i].q);
            chk($sformatf("v%0d_pend", i), {28'h0, bus.PEND}, {28'h0, tv[i].pend});
            chk($sformatf("v%0d_upd", i), {31'h0, bus.UPD}, {31'h0, tv[i].upd});
        end
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0);
        step();
        drive(1'b1, 1'b1, 1'b0, 4'b0000, 32'h0);
        step();
        chk("mode_switch_commit_q", bus.Q, 32'hA5A5A5CC);
        chk("mode_switch_commit_upd", {31'h0, bus.UPD}, 32'h1);
        drive(1'b1, 1'b0, 1'b0, 4'b0000, 32'h0);
        step();
        chk("upd_drop", {31'h0, bus.UPD}, 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
